core_inst_seq: RTL and testbench

Instruction sequencer that drives the 34-bit `inst` bus of `core` for one full convolution pass. For each kernel index (kij), it:
- fetches weights from activation/weight SRAM into L0,
- loads the weights into the MAC array,
- streams activations through execute,
- drains the OFIFO into psum SRAM, with accumulation on every kij after the first.

It replaces the hand-written testbench instruction stream and sits directly in front of `core`. It consumes `ofifo_valid` and emits `inst`.

---
 rtl/core_pkg.sv | 39 +++
 rtl/core_inst_seq_phase_cnt.sv | 27 ++
 rtl/core_inst_seq.sv | 203 ++++++++++++++++++++
 tb/tb_core_inst_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core instruction word and the sequencer states.
package core_pkg;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;

  // Bit positions of the core instruction word fields.
  localparam int ACC_B      = 33;
  localparam int CEN_PMEM_B = 32;
  localparam int WEN_PMEM_B = 31;
  localparam int A_PMEM_MSB = 30;
  localparam int A_PMEM_LSB = 20;
  localparam int CEN_XMEM_B = 19;
  localparam int WEN_XMEM_B = 18;
  localparam int A_XMEM_MSB = 17;
  localparam int A_XMEM_LSB = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXECUTE_B  = 1;
  localparam int LOAD_B     = 0;

  // Both SRAMs deselected and write-protected, everything else quiet.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    IDLE,
    W_FETCH,
    W_LOAD,
    FLUSH,
    A_FETCH,
    A_EXEC,
    DRAIN,
    ACC
  } state_t;

endpackage

// File: rtl/core_inst_seq_phase_cnt.sv
// Loadable down-counter; tc flags the last cycle of the current phase.
module phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] count;

  // Load the phase length on entry, then count down and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer: drives the core inst bus through one full
// convolution pass (weight fetch/load, flush, activation fetch/execute,
// OFIFO drain into psum SRAM) for every kernel index.
module core_inst_seq
  import core_pkg::*;
#(
  parameter int          row     = 8,
  parameter int          col     = 8,
  parameter int          len_kij = 9,
  parameter int          len_nij = 36,
  parameter logic [10:0] A_BASE  = 11'd0,
  parameter logic [10:0] W_BASE  = 11'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(2 * len_nij + row + col + 2);
  localparam int KW = $clog2(len_kij + 1);

  state_t            state;
  state_t            next_state;
  logic [CW-1:0]     i;
  logic [CW-1:0]     next_i;
  logic [KW-1:0]     kij;
  logic [KW-1:0]     next_kij;
  logic              load;
  logic [CW-1:0]     load_value;
  logic              tc;
  logic              next_done;
  logic [INST_W-1:0] next_inst;

  phase_cnt #(
    .W(CW)
  ) u_phase_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_value(load_value),
    .tc        (tc)
  );

  // Next-state logic; every state change reloads the phase counter with its length-1.
  always_comb begin
    next_state = state;
    next_kij   = kij;
    load       = 1'b0;
    load_value = '0;
    next_done  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done) begin
          next_state = W_FETCH;
          next_kij   = '0;
          load       = 1'b1;
          load_value = CW'(col);
        end
      end
      W_FETCH: begin
        if (tc) begin
          next_state = W_LOAD;
          load       = 1'b1;
          load_value = CW'(col - 1);
        end
      end
      W_LOAD: begin
        if (tc) begin
          next_state = FLUSH;
          load       = 1'b1;
          load_value = CW'(row + col - 1);
        end
      end
      FLUSH: begin
        if (tc) begin
          next_state = A_FETCH;
          load       = 1'b1;
          load_value = CW'(len_nij);
        end
      end
      A_FETCH: begin
        if (tc) begin
          next_state = A_EXEC;
          load       = 1'b1;
          load_value = CW'(len_nij - 1);
        end
      end
      A_EXEC: begin
        // DRAIN is only occupied while the OFIFO has nothing ready yet.
        if (tc) begin
          load = 1'b1;
          if (ofifo_valid) begin
            next_state = ACC;
            load_value = CW'(2 * len_nij - 1);
          end else begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (ofifo_valid) begin
          next_state = ACC;
          load       = 1'b1;
          load_value = CW'(2 * len_nij - 1);
        end
      end
      ACC: begin
        if (tc) begin
          load = 1'b1;
          if (kij != KW'(len_kij - 1)) begin
            next_state = W_FETCH;
            next_kij   = kij + 1'b1;
            load_value = CW'(col);
          end else begin
            next_state = IDLE;
            next_kij   = '0;
            next_done  = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (load) begin
      next_i = '0;
    end else if (state == IDLE || state == DRAIN) begin
      next_i = i;
    end else begin
      next_i = i + 1'b1;
    end
  end

  // Build the instruction word for the state being entered so the register lines up with it.
  always_comb begin
    next_inst = IDLE_INST;
    case (next_state)
      W_FETCH: begin
        if (next_i < CW'(col)) begin
          next_inst[CEN_XMEM_B] = 1'b0;
          next_inst[A_XMEM_MSB:A_XMEM_LSB] =
            W_BASE + ADDR_W'(next_kij * col) + ADDR_W'(next_i);
        end
        if (next_i != '0) begin
          next_inst[L0_WR_B] = 1'b1;
        end
      end
      W_LOAD: begin
        next_inst[L0_RD_B] = 1'b1;
        next_inst[LOAD_B]  = 1'b1;
      end
      A_FETCH: begin
        if (next_i < CW'(len_nij)) begin
          next_inst[CEN_XMEM_B] = 1'b0;
          next_inst[A_XMEM_MSB:A_XMEM_LSB] = A_BASE + ADDR_W'(next_i);
        end
        if (next_i != '0) begin
          next_inst[L0_WR_B] = 1'b1;
        end
      end
      A_EXEC: begin
        next_inst[L0_RD_B]   = 1'b1;
        next_inst[EXECUTE_B] = 1'b1;
      end
      ACC: begin
        next_inst[CEN_PMEM_B] = 1'b0;
        next_inst[A_PMEM_MSB:A_PMEM_LSB] = ADDR_W'(next_i >> 1);
        if (next_i[0]) begin
          next_inst[WEN_PMEM_B] = 1'b0;
          next_inst[OFIFO_RD_B] = 1'b1;
          next_inst[ACC_B]      = (next_kij != '0);
        end
      end
      default: begin
        next_inst = IDLE_INST;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops straight back to the idle word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      kij   <= '0;
      inst  <= IDLE_INST;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      i     <= next_i;
      kij   <= next_kij;
      inst  <= next_inst;
      busy  <= (next_state != IDLE);
      done  <= next_done;
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed testbench for core_inst_seq with default parameters.
module tb_core_inst_seq;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  core_inst_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ofifo_valid(ofifo_valid),
    .inst       (inst),
    .busy       (busy),
    .done       (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequencer never finishes.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    ofifo_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (inst !== IDLE_W) begin
      errors++;
      $display("[TB] FAIL reset_inst: inst=%h expected %h", inst, IDLE_W);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: busy=%b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: done=%b expected 0", done);
    end
    start = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (inst !== IDLE_W || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: inst=%h busy=%b expected %h busy=0", inst, busy, IDLE_W);
    end
  endtask

  task automatic test_weight_phase();
    logic [33:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wfetch_busy: busy=%b expected 1", busy);
    end
    for (int c = 0; c < 9; c++) begin
      exp = IDLE_W;
      if (c < 8) begin
        exp[19]   = 1'b0;
        exp[17:7] = 11'(1024 + c);
      end
      if (c >= 1) exp[2] = 1'b1;
      checks++;
      if (inst !== exp) begin
        errors++;
        $display("[TB] FAIL wfetch c=%0d: inst=%h expected %h", c, inst, exp);
      end
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      exp = IDLE_W;
      exp[3] = 1'b1;
      exp[0] = 1'b1;
      checks++;
      if (inst !== exp) begin
        errors++;
        $display("[TB] FAIL wload c=%0d: inst=%h expected %h", c, inst, exp);
      end
      tick();
    end
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (inst !== IDLE_W) begin
        errors++;
        $display("[TB] FAIL flush c=%0d: inst=%h expected %h", c, inst, IDLE_W);
      end
      tick();
    end
    for (int c = 0; c < 37; c++) begin
      exp = IDLE_W;
      if (c < 36) begin
        exp[19]   = 1'b0;
        exp[17:7] = 11'(c);
      end
      if (c >= 1) exp[2] = 1'b1;
      checks++;
      if (inst !== exp) begin
        errors++;
        $display("[TB] FAIL afetch c=%0d: inst=%h expected %h", c, inst, exp);
      end
      tick();
    end
    for (int c = 0; c < 36; c++) begin
      exp = IDLE_W;
      exp[3] = 1'b1;
      exp[1] = 1'b1;
      checks++;
      if (inst !== exp) begin
        errors++;
        $display("[TB] FAIL aexec c=%0d: inst=%h expected %h", c, inst, exp);
      end
      tick();
    end
  endtask

  task automatic test_drain_hold();
    logic [33:0] exp;
    for (int c = 0; c < 50; c++) begin
      checks++;
      if (inst !== IDLE_W || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL drain_hold c=%0d: inst=%h busy=%b expected %h busy=1", c, inst, busy, IDLE_W);
      end
      tick();
    end
    ofifo_valid = 1'b1;
    tick();
    ofifo_valid = 1'b0;
    exp = IDLE_W;
    exp[32] = 1'b0;
    checks++;
    if (inst !== exp) begin
      errors++;
      $display("[TB] FAIL drain_exit: inst=%h expected %h", inst, exp);
    end
  endtask

  task automatic test_accumulate();
    logic [33:0] exp;
    for (int c = 1; c < 72; c++) begin
      tick();
      exp = IDLE_W;
      exp[32]    = 1'b0;
      exp[30:20] = 11'(c / 2);
      if (c % 2 == 1) begin
        exp[31] = 1'b0;
        exp[6]  = 1'b1;
      end
      checks++;
      if (inst !== exp) begin
        errors++;
        $display("[TB] FAIL acc_kij0 c=%0d: inst=%h expected %h", c, inst, exp);
      end
    end
    tick();
    exp = IDLE_W;
    exp[19]   = 1'b0;
    exp[17:7] = 11'd1032;
    checks++;
    if (inst !== exp) begin
      errors++;
      $display("[TB] FAIL wfetch_kij1: inst=%h expected %h", inst, exp);
    end
    repeat (105) tick();
    tick();
    checks++;
    if (inst !== IDLE_W) begin
      errors++;
      $display("[TB] FAIL drain_kij1: inst=%h expected %h", inst, IDLE_W);
    end
    ofifo_valid = 1'b1;
    tick();
    ofifo_valid = 1'b0;
    tick();
    exp = IDLE_W;
    exp[33] = 1'b1;
    exp[32] = 1'b0;
    exp[31] = 1'b0;
    exp[6]  = 1'b1;
    checks++;
    if (inst !== exp) begin
      errors++;
      $display("[TB] FAIL acc_kij1 c=1: inst=%h expected %h", inst, exp);
    end
    repeat (2) tick();
    exp[30:20] = 11'd1;
    checks++;
    if (inst !== exp) begin
      errors++;
      $display("[TB] FAIL acc_kij1 c=3: inst=%h expected %h", inst, exp);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [33:0] exp;
    int bad;
    repeat (68) tick();
    tick();
    repeat (80) tick();
    exp = IDLE_W;
    exp[3] = 1'b1;
    exp[1] = 1'b1;
    checks++;
    if (inst !== exp) begin
      errors++;
      $display("[TB] FAIL pre_reset_aexec: inst=%h expected %h", inst, exp);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: inst=%h busy=%b done=%b expected %h 0 0", inst, busy, done, IDLE_W);
    end
    repeat (2) tick();
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || inst !== IDLE_W) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: bad_cycles=%0d expected 0", bad);
    end
  endtask

  task automatic test_full_pass();
    logic [33:0] exp;
    int n;
    int busy_low;
    bit found;
    ofifo_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp = IDLE_W;
    exp[19]   = 1'b0;
    exp[17:7] = 11'd1024;
    checks++;
    if (inst !== exp || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_first: inst=%h busy=%b expected %h busy=1", inst, busy, exp);
    end
    n = 0;
    busy_low = 0;
    found = 1'b0;
    while (n < 3000 && !found) begin
      tick();
      n++;
      if (done === 1'b1) found = 1'b1;
      else if (busy !== 1'b1) busy_low++;
    end
    checks++;
    if (!found || n != 1602) begin
      errors++;
      $display("[TB] FAIL pass_length: done after %0d cycles (found=%0d) expected 1602", n, found);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_at_done: busy=%b expected 0", busy);
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("[TB] FAIL busy_gap: busy low for %0d cycles expected 0", busy_low);
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp;
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || inst !== IDLE_W) begin
      errors++;
      $display("[TB] FAIL start_at_done: busy=%b done=%b inst=%h expected 0 0 %h", busy, done, inst, IDLE_W);
    end
    tick();
    start = 1'b0;
    exp = IDLE_W;
    exp[19]   = 1'b0;
    exp[17:7] = 11'd1024;
    checks++;
    if (busy !== 1'b1 || inst !== exp) begin
      errors++;
      $display("[TB] FAIL start_after_done: busy=%b inst=%h expected 1 %h", busy, inst, exp);
    end
  endtask

  // Run each scenario in order, then report.
  initial begin
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    test_reset();
    test_weight_phase();
    test_drain_hold();
    test_accumulate();
    test_reset_mid_exec();
    test_full_pass();
    test_back_to_back();
    reset = 1'b1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
